// File: rtl/gear_pkg.sv
// ---------------------------------------------------------------------------
// gear_pkg
// Shared types and constants for the gear-shift sequencer:
//   - gear_state_e : FSM states (one per LED)
//   - gear_mode_e  : selector modes (D1..D4 all collapse to MODE_D)
//   - LED_* / SW_* : bit positions in the LED and switch vectors
//   - state_to_led : one-hot LED encoding of a state
//   - state_to_mode, sw_to_mode, mode_entry : mode helpers used by the FSM
// ---------------------------------------------------------------------------
package gear_pkg;

  typedef enum logic [2:0] {
    ST_PARK,
    ST_REV,
    ST_NEUT,
    ST_D1,
    ST_D2,
    ST_D3,
    ST_D4
  } gear_state_e;

  typedef enum logic [1:0] {
    MODE_P,
    MODE_R,
    MODE_N,
    MODE_D
  } gear_mode_e;

  localparam int LED_W  = 7;
  localparam int LED_R1 = 6;
  localparam int LED_N1 = 5;
  localparam int LED_P1 = 4;
  localparam int LED_D4 = 3;
  localparam int LED_D3 = 2;
  localparam int LED_D2 = 1;
  localparam int LED_D1 = 0;

  localparam int SW_W = 4;
  localparam int SW_P = 3;
  localparam int SW_R = 2;
  localparam int SW_N = 1;
  localparam int SW_D = 0;

  // Unused encodings fall back to the Park LED so the output stays one-hot.
  function automatic logic [LED_W-1:0] state_to_led(input gear_state_e s);
    logic [LED_W-1:0] led;
    led = '0;
    case (s)
      ST_PARK: led[LED_P1] = 1'b1;
      ST_REV:  led[LED_R1] = 1'b1;
      ST_NEUT: led[LED_N1] = 1'b1;
      ST_D1:   led[LED_D1] = 1'b1;
      ST_D2:   led[LED_D2] = 1'b1;
      ST_D3:   led[LED_D3] = 1'b1;
      ST_D4:   led[LED_D4] = 1'b1;
      default: led[LED_P1] = 1'b1;
    endcase
    return led;
  endfunction

  function automatic gear_mode_e state_to_mode(input gear_state_e s);
    gear_mode_e m;
    case (s)
      ST_PARK: m = MODE_P;
      ST_REV:  m = MODE_R;
      ST_NEUT: m = MODE_N;
      default: m = MODE_D;
    endcase
    return m;
  endfunction

  // Only meaningful when exactly one switch bit is set.
  function automatic gear_mode_e sw_to_mode(input logic [SW_W-1:0] s);
    gear_mode_e m;
    m = MODE_N;
    if (s[SW_P])      m = MODE_P;
    else if (s[SW_R]) m = MODE_R;
    else if (s[SW_D]) m = MODE_D;
    return m;
  endfunction

  // Entering Drive always starts in first gear.
  function automatic gear_state_e mode_entry(input gear_mode_e m);
    gear_state_e s;
    case (m)
      MODE_P:  s = ST_PARK;
      MODE_R:  s = ST_REV;
      MODE_N:  s = ST_NEUT;
      default: s = ST_D1;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/gear_shift_sequencer_if.sv
// ---------------------------------------------------------------------------
// gear_shift_sequencer_if
// Selector-side bundle of the gear-shift sequencer.
//   sw    : raw {P,R,N,D} switches (asynchronous)
//   brake : brake pedal (synchronous)
//   speed : unsigned speed code 0..15 (synchronous)
//   led   : one-hot {R1,N1,P1,D4,D3,D2,D1}
//   fault : high while the held request is illegal
// master drives the inputs and observes led/fault; slave is the sequencer.
// ---------------------------------------------------------------------------
interface gear_shift_sequencer_if;
  import gear_pkg::*;

  logic [SW_W-1:0]  sw;
  logic             brake;
  logic [3:0]       speed;
  logic [LED_W-1:0] led;
  logic             fault;

  modport master (
    output sw,
    output brake,
    output speed,
    input  led,
    input  fault
  );

  modport slave (
    input  sw,
    input  brake,
    input  speed,
    output led,
    output fault
  );

endinterface

// File: rtl/switch_debouncer.sv
// ---------------------------------------------------------------------------
// switch_debouncer
// Two-flop synchroniser followed by a whole-vector debouncer. The debounced
// value only follows the synchronised value after it has differed for
// DEB_CYCLES consecutive cycles; any return to agreement restarts the count.
//   clk, reset : clock and synchronous active-high reset
//   raw        : asynchronous input vector
//   deb        : debounced vector (resets to RESET_VALUE)
// ---------------------------------------------------------------------------
module switch_debouncer #(
  parameter int               WIDTH       = 4,
  parameter int               DEB_CYCLES  = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] deb
);

  localparam int               CNT_W    = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [WIDTH-1:0] sync1_reg;
  logic [WIDTH-1:0] sync2_reg;
  logic [WIDTH-1:0] deb_reg;
  logic [WIDTH-1:0] deb_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
    end
  end

  // The counter reaching CNT_LAST while still mismatched means the new value
  // has been seen for DEB_CYCLES cycles in a row: accept it.
  always_comb begin
    deb_next = deb_reg;
    cnt_next = cnt_reg;
    if (sync2_reg == deb_reg) begin
      cnt_next = '0;
    end else if (cnt_reg == CNT_LAST) begin
      deb_next = sync2_reg;
      cnt_next = '0;
    end else begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      deb_reg <= RESET_VALUE;
      cnt_reg <= '0;
    end else begin
      deb_reg <= deb_next;
      cnt_reg <= cnt_next;
    end
  end

  assign deb = deb_reg;

endmodule

// File: rtl/gear_shift_sequencer.sv
// ---------------------------------------------------------------------------
// gear_shift_sequencer
// Gear-selector state machine. Conditions the raw P/R/N/D switches, enforces
// the Park/Reverse/Neutral/Drive interlocks against brake and speed, and
// auto-steps Drive through D1..D4 with downshift hysteresis and a minimum
// dwell between shifts.
//   clk   : clock
//   reset : synchronous active-high reset (state -> Park)
//   bus   : slave side of gear_shift_sequencer_if (sw, brake, speed in;
//           registered one-hot led and fault out)
// ---------------------------------------------------------------------------
module gear_shift_sequencer
  import gear_pkg::*;
#(
  parameter int DEB_CYCLES   = 4,
  parameter int DWELL_CYCLES = 8,
  parameter int UP1          = 4,
  parameter int UP2          = 8,
  parameter int UP3          = 12,
  parameter int HYST         = 2
) (
  input logic                   clk,
  input logic                   reset,
  gear_shift_sequencer_if.slave bus
);

  localparam int              DW_W       = $clog2(DWELL_CYCLES + 1);
  localparam logic [DW_W-1:0] DWELL_LOAD = DW_W'(DWELL_CYCLES);

  // Thresholds widened by one bit so UP - HYST never wraps against speed.
  localparam logic [4:0] UP1_T = 5'(UP1);
  localparam logic [4:0] UP2_T = 5'(UP2);
  localparam logic [4:0] UP3_T = 5'(UP3);
  localparam logic [4:0] DN1_T = 5'(UP1 - HYST);
  localparam logic [4:0] DN2_T = 5'(UP2 - HYST);
  localparam logic [4:0] DN3_T = 5'(UP3 - HYST);

  logic [SW_W-1:0]  deb_sw;
  gear_state_e      state_reg;
  gear_state_e      state_next;
  logic             fault_reg;
  logic             fault_next;
  logic [LED_W-1:0] led_reg;
  logic [DW_W-1:0]  dwell_reg;
  logic             move_ok;
  logic             req_valid;
  gear_mode_e       req_mode;
  gear_mode_e       cur_mode;
  logic             speed_zero;
  logic             dwell_zero;
  logic [4:0]       speed_ext;

  switch_debouncer #(
    .WIDTH       (SW_W),
    .DEB_CYCLES  (DEB_CYCLES),
    .RESET_VALUE (4'b1000)
  ) u_debouncer (
    .clk   (clk),
    .reset (reset),
    .raw   (bus.sw),
    .deb   (deb_sw)
  );

  // Zero or several switches closed is "no request": hold, no fault.
  assign req_valid  = $onehot(deb_sw);
  assign req_mode   = sw_to_mode(deb_sw);
  assign cur_mode   = state_to_mode(state_reg);
  assign speed_zero = (bus.speed == 4'd0);
  assign dwell_zero = (dwell_reg == '0);
  assign speed_ext  = {1'b0, bus.speed};

  // A mode change is checked first so it always beats an auto-shift. A
  // rejected change leaves the state alone and is simply re-evaluated on the
  // next cycle, raising fault for as long as it stays illegal.
  always_comb begin
    state_next = state_reg;
    fault_next = 1'b0;
    move_ok    = 1'b1;
    if (req_valid && (req_mode != cur_mode)) begin
      if ((cur_mode == MODE_P) && !bus.brake) begin
        move_ok = 1'b0;
      end
      if (((req_mode == MODE_P) || (req_mode == MODE_R)) && !speed_zero) begin
        move_ok = 1'b0;
      end
      if ((req_mode == MODE_D) && (cur_mode == MODE_R) && !speed_zero) begin
        move_ok = 1'b0;
      end
      if (move_ok) begin
        state_next = mode_entry(req_mode);
      end else begin
        fault_next = 1'b1;
      end
    end else if (req_valid && (req_mode == MODE_D) && dwell_zero) begin
      case (state_reg)
        ST_D1: begin
          if (speed_ext >= UP1_T) state_next = ST_D2;
        end
        ST_D2: begin
          if (speed_ext >= UP2_T)      state_next = ST_D3;
          else if (speed_ext < DN1_T)  state_next = ST_D1;
        end
        ST_D3: begin
          if (speed_ext >= UP3_T)      state_next = ST_D4;
          else if (speed_ext < DN2_T)  state_next = ST_D2;
        end
        ST_D4: begin
          if (speed_ext < DN3_T)       state_next = ST_D3;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_PARK;
      fault_reg <= 1'b0;
      led_reg   <= state_to_led(ST_PARK);
    end else begin
      state_reg <= state_next;
      fault_reg <= fault_next;
      led_reg   <= state_to_led(state_next);
    end
  end

  // Dwell restarts on every state change and saturates at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      dwell_reg <= '0;
    end else if (state_next != state_reg) begin
      dwell_reg <= DWELL_LOAD;
    end else if (!dwell_zero) begin
      dwell_reg <= dwell_reg - 1'b1;
    end
  end

  assign bus.led   = led_reg;
  assign bus.fault = fault_reg;

endmodule

// File: tb/tb_gear_shift_sequencer.sv
// ---------------------------------------------------------------------------
// tb_gear_shift_sequencer
// Scenario bench for gear_shift_sequencer at default parameters. Each
// scenario queues the led/fault values it expects, advances the clock, and
// pops the queue against the outputs sampled 1 ns after the clock edge.
// ---------------------------------------------------------------------------
module tb_gear_shift_sequencer;
  import gear_pkg::*;

  localparam logic [3:0] SW_PARK = 4'b1000;
  localparam logic [3:0] SW_REVS = 4'b0100;
  localparam logic [3:0] SW_NEUT = 4'b0010;
  localparam logic [3:0] SW_DRV  = 4'b0001;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  gear_shift_sequencer_if bus();

  gear_shift_sequencer #(
    .DEB_CYCLES   (4),
    .DWELL_CYCLES (8),
    .UP1          (4),
    .UP2          (8),
    .UP3          (12),
    .HYST         (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string      tag;
    logic [6:0] led;
    logic       fault;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("pass %s got=%0h", tag, got);
    end
  endtask

  task automatic push_exp(input string tag, input logic [6:0] led, input logic fault);
    exp_t e;
    e.tag   = tag;
    e.led   = led;
    e.fault = fault;
    sb_q.push_back(e);
  endtask

  task automatic pop_cmp();
    exp_t e;
    if (sb_q.size() == 0) begin
      chk("sb_underflow", 32'(sb_q.size()), 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk({e.tag, "_led"}, 32'(bus.led), 32'(e.led));
      chk({e.tag, "_fault"}, 32'(bus.fault), 32'(e.fault));
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_led(input logic [6:0] target, input int budget);
    int edges;
    edges = 0;
    while ((bus.led !== target) && (edges < budget)) begin
      step(1);
      edges++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] last_led;
    int         last_edge;
    int         gap;

    // Reset
    reset     = 1'b1;
    bus.sw    = SW_PARK;
    bus.brake = 1'b0;
    bus.speed = 4'd0;
    push_exp("reset", 7'h10, 1'b0);
    step(2);
    pop_cmp();
    reset = 1'b0;
    push_exp("post_reset", 7'h10, 1'b0);
    step(1);
    pop_cmp();

    // Leaving Park needs the brake
    bus.sw = SW_NEUT;
    push_exp("park_e6", 7'h10, 1'b0);
    step(6);
    pop_cmp();
    push_exp("park_nobrake", 7'h10, 1'b1);
    step(1);
    pop_cmp();
    push_exp("park_retry", 7'h10, 1'b1);
    step(3);
    pop_cmp();
    bus.brake = 1'b1;
    push_exp("park_exit", 7'h20, 1'b0);
    step(1);
    pop_cmp();
    bus.brake = 1'b0;

    // Bouncing N<->D must not be accepted
    for (int i = 0; i < 10; i++) begin
      bus.sw = (i % 2 == 0) ? SW_DRV : SW_NEUT;
      push_exp("bounce", 7'h20, 1'b0);
      step(2);
      pop_cmp();
    end
    bus.sw = SW_DRV;
    push_exp("drive_e6", 7'h20, 1'b0);
    step(6);
    pop_cmp();
    push_exp("drive_e7", 7'h01, 1'b0);
    step(1);
    pop_cmp();

    // Upshift ramp: speed is already past each threshold once dwell expires,
    // so every shift lands exactly DWELL_CYCLES+1 edges after the previous.
    push_exp("up_d2", 7'h02, 1'b0);
    push_exp("up_d3", 7'h04, 1'b0);
    push_exp("up_d4", 7'h08, 1'b0);
    last_led  = 7'h01;
    last_edge = 0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      if (bus.speed != 4'd15) bus.speed = bus.speed + 4'd1;
      step(1);
      if (bus.led !== last_led) begin
        gap = cyc - last_edge;
        chk("up_gap", 32'(gap), 32'd9);
        pop_cmp();
        last_led  = bus.led;
        last_edge = cyc;
        if (bus.led === 7'h08) break;
      end
    end
    while (sb_q.size() != 0) pop_cmp();
    push_exp("up_final", 7'h08, 1'b0);
    pop_cmp();

    // Hysteresis: speed 5 settles in D2, 3 holds D2, 1 drops to D1
    bus.speed = 4'd5;
    push_exp("hy_d2", 7'h02, 1'b0);
    wait_led(7'h02, 40);
    pop_cmp();
    push_exp("hy_d2_hold5", 7'h02, 1'b0);
    step(20);
    pop_cmp();
    bus.speed = 4'd3;
    push_exp("hy_d2_hold3", 7'h02, 1'b0);
    step(20);
    pop_cmp();
    bus.speed = 4'd1;
    push_exp("hy_d1", 7'h01, 1'b0);
    step(1);
    pop_cmp();

    // Reverse interlock from D3
    bus.speed = 4'd9;
    push_exp("rv_d3", 7'h04, 1'b0);
    wait_led(7'h04, 40);
    pop_cmp();
    bus.speed = 4'd6;
    push_exp("rv_d3_hold", 7'h04, 1'b0);
    step(12);
    pop_cmp();
    bus.sw = SW_REVS;
    push_exp("rv_e6", 7'h04, 1'b0);
    step(6);
    pop_cmp();
    push_exp("rv_blocked", 7'h04, 1'b1);
    step(1);
    pop_cmp();
    push_exp("rv_retry", 7'h04, 1'b1);
    step(3);
    pop_cmp();
    bus.speed = 4'd0;
    push_exp("rv_enter", 7'h40, 1'b0);
    step(1);
    pop_cmp();

    // Two switches closed is no request
    bus.sw = 4'b0011;
    push_exp("no_request", 7'h40, 1'b0);
    step(10);
    pop_cmp();

    // Reset in the middle of a debounce
    bus.sw = SW_NEUT;
    step(3);
    reset  = 1'b1;
    bus.sw = SW_PARK;
    push_exp("rst_mid", 7'h10, 1'b0);
    step(1);
    pop_cmp();
    reset = 1'b0;
    push_exp("rst_idle", 7'h10, 1'b0);
    step(12);
    pop_cmp();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gear_shift_sequencer.md
# gear_shift_sequencer

- Sequences the gear-selector machine.
- Takes the raw P/R/N/D selector switches, a brake input and a vehicle-speed code, and synchronises and debounces the switches.
- Enforces the legal mode transitions between Park, Reverse, Neutral and Drive, and auto-steps Drive through D1–D4 with hysteresis and a minimum dwell time.
- Drives the one-hot gear LED vector consumed by the Tiny Tapeout top, plus a fault flag routed to the spare `io_out[7]`.

## Interface
Parameters:
- `DEB_CYCLES`, 4 — consecutive stable cycles required before a switch change is accepted (≥2).
- `DWELL_CYCLES`, 8 — minimum cycles between consecutive auto-shifts in Drive (≥1).
- `UP1`, 4 — speed at which D1→D2 upshift occurs.
- `UP2`, 8 — speed at which D2→D3 upshift occurs.
- `UP3`, 12 — speed at which D3→D4 upshift occurs.
- `HYST`, 2 — downshift hysteresis (must be < UP1).

Ports:
- `clk` in 1 — global clock.
- `reset` in 1 — synchronous, active-high reset.
- `sw` in 4 — raw switches {P,R,N,D}, asynchronous to `clk`.
- `brake` in 1 — brake pedal, treated as synchronous.
- `speed` in 4 — unsigned speed code 0..15, treated as synchronous.
- `led` out 7 — {R1,N1,P1,D4,D3,D2,D1}, one-hot and registered.
- `fault` out 1 — registered; high while the held request is illegal.

## Operation
Input conditioning:
- Two-flop synchroniser on `sw`.
- Debouncer:
  - Counter increments while the synchronised value ≠ the debounced value, and clears when they are equal.
  - When the counter reaches `DEB_CYCLES-1` with a mismatch still present: the debounced value ← the synchronised value and the counter ← 0.

Request decode (debounced):
- Exactly one bit set gives a valid request for that mode.
- Zero or more than one bit set is "no request": hold the current state and keep `fault` = 0.

States: PARK, REV, NEUT, D1, D2, D3, D4. Each maps to exactly one LED bit.

Mode transitions, evaluated every cycle while the request mode ≠ the current mode (D1–D4 all count as mode D):
- Leaving PARK requires `brake`=1; otherwise fault.
- Entering PARK or REV requires `speed`=0; otherwise fault.
- Entering D from REV requires `speed`=0; otherwise fault.
- NEUT is always enterable.
- An accepted entry into D goes to D1.
- A rejected request leaves the state unchanged and is retried each cycle. `fault` = 1 exactly while the request is pending and illegal.

Auto-shift in Drive (request = D), only when the dwell counter is 0:
- Upshift: D1→D2 if `speed`≥UP1; D2→D3 if ≥UP2; D3→D4 if ≥UP3.
- Downshift: D4→D3 if `speed`<UP3−HYST; D3→D2 if <UP2−HYST; D2→D1 if <UP1−HYST.
- At most one step per shift.
- A mode change out of D takes priority over an auto-shift in the same cycle.

Dwell counter:
- Loads `DWELL_CYCLES` on every state change.
- Decrements by 1 per cycle down to a floor of 0; never wraps.

Reset:
- State = PARK, so `led` = 7'b0010000 and `fault` = 0.
- Debounced value = 4'b1000 (P); synchroniser flops = 0; debounce counter = 0; dwell counter = 0.
- Reset mid-shift or mid-debounce aborts immediately with no residual pending request.

## Timing
- A raw `sw` change held stable reaches the debounced value `DEB_CYCLES`+2 edges after first being presented.
- `led` updates on the next edge after that: `DEB_CYCLES`+3 edges total (7 at defaults).
- `brake` and `speed` affect `led` and `fault` on the next edge (1-cycle latency).
- After any shift, the next auto-shift occurs no earlier than `DWELL_CYCLES`+1 edges later.
- A bounce shorter than `DEB_CYCLES` cycles never changes `led` or `fault`.
- `led` is always exactly one-hot, including during reset.

## Structure
- Package `gear_pkg` holds:
  - the state enum;
  - the LED bit positions (R1=6, N1=5, P1=4, D4..D1=3..0);
  - the switch bit positions (P=3, R=2, N=1, D=0);
  - a `state_to_led` function.
- Sub-module `switch_debouncer` (parameter `WIDTH`, `DEB_CYCLES`) contains the synchroniser plus the debounce counter for the full vector.
- The top of this block holds the FSM, the dwell counter and the output registers.

## Test plan
1. **Reset:** assert `reset` for 2 cycles → `led`=7'h10, `fault`=0.
2. **Park exit needs brake:** from PARK, `sw`=N (4'b0010) with `brake`=0 → `fault`=1 and `led` stays 7'h10. Then raise `brake` → next edge `led`=7'h20, `fault`=0.
3. **Debounce:** `sw` toggles N↔D every 2 cycles for 20 cycles → no `led` change. Then hold D → `led`=7'h01 exactly 7 edges later.
4. **Upshift ramp:** in D1, `speed` ramps 0→15 → D2, D3, D4 in order, each shift ≥9 edges after the previous one; final `led`=7'h08.
5. **Hysteresis and downshift:** in D2 at `speed`=5, drop `speed` to 3 → stays D2. Drop to 1 → D1 after dwell expires.
6. **Reverse interlock:** `speed`=6 in D3, request R → `fault`=1 and the state holds D3. `speed`=0 → REV (`led`=7'h40), `fault`=0.
